// File: rtl/fork_ctrl.sv
// Two-way eager stream fork: one registered beat is broadcast to two
// valid/ready branches that complete independently. Optional counters: FORK_CTRL_STATS_EN.
module fork_ctrl #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] i_dat,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic          en0,
  input  logic          en1,
  output logic [DW-1:0] o0_dat,
  output logic          o0_valid,
  input  logic          o0_ready,
  output logic [DW-1:0] o1_dat,
  output logic          o1_valid,
  input  logic          o1_ready
`ifdef FORK_CTRL_STATS_EN
  ,
  output logic [31:0]   beat_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  // State bits are the pending flags themselves: {pend0, pend1}.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ONLY1 = 2'b01,
    ONLY0 = 2'b10,
    BOTH  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dat_q;
  logic          pend0, pend1;
  logic          acc;

  assign pend0 = state_q[1];
  assign pend1 = state_q[0];

  // A branch frees its slot either when idle or when it fires this cycle,
  // which lets a new beat be accepted alongside the final fire.
  assign i_ready = (~pend0 | o0_ready) & (~pend1 | o1_ready);
  assign acc     = i_valid & i_ready;

  always_comb begin
    state_d = state_q;
    if (acc) begin
      state_d = state_t'({en0, en1});
    end else begin
      state_d = state_t'({pend0 & ~o0_ready, pend1 & ~o1_ready});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        dat_q <= i_dat;
      end
    end
  end

  assign o0_valid = pend0;
  assign o1_valid = pend1;
  assign o0_dat   = dat_q;
  assign o1_dat   = dat_q;

`ifdef FORK_CTRL_STATS_EN
  // Dropped beats (both enables low) still count as accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (acc) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (i_valid && !i_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fork_ctrl.sv
// Self-checking bench for fork_ctrl: per-branch scoreboard queues are filled at
// acceptance and drained/compared as each branch fires.
module tb_fork_ctrl;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] i_dat = '0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic          en0 = 1'b1, en1 = 1'b1;
  logic [DW-1:0] o0_dat, o1_dat;
  logic          o0_valid, o1_valid;
  logic          o0_ready = 1'b1, o1_ready = 1'b1;
`ifdef FORK_CTRL_STATS_EN
  logic [31:0]   beat_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  fork_ctrl #(.DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .i_dat(i_dat), .i_valid(i_valid), .i_ready(i_ready),
    .en0(en0), .en1(en1),
    .o0_dat(o0_dat), .o0_valid(o0_valid), .o0_ready(o0_ready),
    .o1_dat(o1_dat), .o1_valid(o1_valid), .o1_ready(o1_ready)
`ifdef FORK_CTRL_STATS_EN
    , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // One clock: scoreboard checks at the falling edge, then advance past the rising edge.
  task automatic cycle();
    logic exp_ready;
    @(negedge CLK);
    if (RST_N) begin
      exp_ready = (q0.size() == 0 || o0_ready) && (q1.size() == 0 || o1_ready);
      total++;
      if (o0_valid !== (q0.size() != 0)) begin
        bad++; $display("FAIL o0_valid got=%b want=%b", o0_valid, q0.size() != 0);
      end
      total++;
      if (o1_valid !== (q1.size() != 0)) begin
        bad++; $display("FAIL o1_valid got=%b want=%b", o1_valid, q1.size() != 0);
      end
      total++;
      if (i_ready !== exp_ready) begin
        bad++; $display("FAIL i_ready got=%b want=%b", i_ready, exp_ready);
      end
      if (q0.size() != 0) begin
        total++;
        if (o0_dat !== q0[0]) begin
          bad++; $display("FAIL o0_dat got=%h want=%h", o0_dat, q0[0]);
        end
        if (o0_ready) void'(q0.pop_front());
      end
      if (q1.size() != 0) begin
        total++;
        if (o1_dat !== q1[0]) begin
          bad++; $display("FAIL o1_dat got=%h want=%h", o1_dat, q1[0]);
        end
        if (o1_ready) void'(q1.pop_front());
      end
      if (i_valid && exp_ready) begin
        if (en0) q0.push_back(i_dat);
        if (en1) q1.push_back(i_dat);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({i_ready, o0_valid, o1_valid} !== 3'b100 || o0_dat !== '0 || o1_dat !== '0) begin
      bad++; $display("FAIL reset_state got rdy=%b v0=%b v1=%b d0=%h d1=%h want 1 0 0 0 0",
                      i_ready, o0_valid, o1_valid, o0_dat, o1_dat);
    end
    RST_N = 1'b1;
    repeat (3) cycle();
    total++;
    if ({i_ready, o0_valid, o1_valid} !== 3'b100 || o0_dat !== '0 || o1_dat !== '0) begin
      bad++; $display("FAIL post_reset got rdy=%b v0=%b v1=%b d0=%h d1=%h want 1 0 0 0 0",
                      i_ready, o0_valid, o1_valid, o0_dat, o1_dat);
    end
  endtask

  task automatic test_streaming();
    en0 = 1'b1; en1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_dat = DW'(k);
      cycle();
      total++;
      if (o0_dat !== DW'(k) || o1_dat !== DW'(k) || !o0_valid || !o1_valid) begin
        bad++; $display("FAIL stream_beat%0d got d0=%h d1=%h want %h", k, o0_dat, o1_dat, k);
      end
    end
    i_valid = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_skewed();
    en0 = 1'b1; en1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
    i_valid = 1'b1; i_dat = 32'hA5;
    cycle();
    i_dat = 32'hB6; o1_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++;
      if ({o0_valid, o1_valid} !== 2'b01 || i_ready !== 1'b0 || o1_dat !== 32'hA5) begin
        bad++; $display("FAIL skew_hold%0d got v=%b%b rdy=%b d1=%h want 01 0 a5",
                        k, o0_valid, o1_valid, i_ready, o1_dat);
      end
    end
    o1_ready = 1'b1;
    #1;
    total++;
    if (i_ready !== 1'b1) begin
      bad++; $display("FAIL skew_release_ready got=%b want=1", i_ready);
    end
    cycle();
    i_valid = 1'b0;
    total++;
    if ({o0_valid, o1_valid} !== 2'b11 || o0_dat !== 32'hB6) begin
      bad++; $display("FAIL skew_refill got v=%b%b d=%h want 11 b6", o0_valid, o1_valid, o0_dat);
    end
    repeat (2) cycle();
  endtask

  task automatic test_mask();
    en0 = 1'b0; en1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b0;
    i_valid = 1'b1; i_dat = 32'h11;
    cycle();
    i_valid = 1'b0; en0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      o0_ready = k[0];
      cycle();
      total++;
      if ({o0_valid, o1_valid} !== 2'b01 || o1_dat !== 32'h11) begin
        bad++; $display("FAIL mask_only1_%0d got v=%b%b d1=%h want 01 11", k, o0_valid, o1_valid, o1_dat);
      end
    end
    o0_ready = 1'b1; o1_ready = 1'b1;
    cycle();
    en0 = 1'b0; en1 = 1'b0; i_valid = 1'b1; i_dat = 32'h22;
    cycle();
    i_valid = 1'b0;
    total++;
    if ({o0_valid, o1_valid} !== 2'b00 || i_ready !== 1'b1) begin
      bad++; $display("FAIL drop got v=%b%b rdy=%b want 00 1", o0_valid, o1_valid, i_ready);
    end
    en0 = 1'b1; en1 = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    en0 = 1'b1; en1 = 1'b1; o0_ready = 1'b0; o1_ready = 1'b0;
    i_valid = 1'b1; i_dat = 32'h5A;
    cycle();
    i_valid = 1'b0;
    total++;
    if ({o0_valid, o1_valid} !== 2'b11 || o0_dat !== 32'h5A) begin
      bad++; $display("FAIL mid_setup got v=%b%b d=%h want 11 5a", o0_valid, o1_valid, o0_dat);
    end
    #1 RST_N = 1'b0;
    #1;
    q0.delete(); q1.delete();
    total++;
    if ({o0_valid, o1_valid} !== 2'b00 || o0_dat !== '0 || i_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got v=%b%b d=%h rdy=%b want 00 0 1", o0_valid, o1_valid, o0_dat, i_ready);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    o0_ready = 1'b1; o1_ready = 1'b1;
    @(posedge CLK);
    #1;
    cycle();
  endtask

`ifdef FORK_CTRL_STATS_EN
  task automatic test_stats();
    RST_N = 1'b0; #1; RST_N = 1'b1;
    q0.delete(); q1.delete();
    en0 = 1'b1; en1 = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
    i_valid = 1'b1; i_dat = 32'h1;
    cycle();
    o1_ready = 1'b0; i_dat = 32'h2;
    repeat (4) cycle();
    o1_ready = 1'b1;
    cycle();
    i_dat = 32'h3;
    cycle();
    i_dat = 32'h4; en0 = 1'b0; en1 = 1'b0;
    cycle();
    i_dat = 32'h5; en0 = 1'b1; en1 = 1'b1;
    cycle();
    i_valid = 1'b0;
    repeat (2) cycle();
    total++;
    if (beat_cnt !== 32'd5 || stall_cnt !== 32'd4) begin
      bad++; $display("FAIL stats got beats=%0d stalls=%0d want 5 4", beat_cnt, stall_cnt);
    end
    @(negedge CLK);
    force dut.beat_cnt = 32'hFFFF_FFFF;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.beat_cnt;
    release dut.stall_cnt;
    @(posedge CLK); #1;
    i_valid = 1'b1; i_dat = 32'h6;
    cycle();
    i_valid = 1'b0;
    total++;
    if (beat_cnt !== 32'd0 || stall_cnt !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL stats_wrap got beats=%h stalls=%h want 0 ffffffff", beat_cnt, stall_cnt);
    end
    repeat (2) cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_skewed();
    test_mask();
    test_reset_mid();
`ifdef FORK_CTRL_STATS_EN
    test_stats();
`endif
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++; $display("FAIL drain got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fork_ctrl.md
# fork_ctrl

Two-way eager stream fork controller with per-branch enable masking. It accepts one beat from a single valid/ready producer, holds it in one register and presents it to two independent valid/ready consumers. Each branch completes its handshake on its own schedule, and the next beat is accepted only once both branches have taken the current one. It sits wherever the stateless bit-duplicating fork must cross stream boundaries that apply back-pressure, for example when broadcasting a request to two pipelines.

## Interface
Parameters
- DW, 32, data width of every channel (≥1)

Ports
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- i_dat  in  DW  producer data
- i_valid  in  1  producer beat valid
- i_ready  out  1  controller can accept a beat this cycle
- en0  in  1  branch 0 enable, sampled at acceptance
- en1  in  1  branch 1 enable, sampled at acceptance
- o0_dat  out  DW  branch 0 data
- o0_valid  out  1  branch 0 beat pending
- o0_ready  in  1  branch 0 consumer ready
- o1_dat  out  DW  branch 1 data
- o1_valid  out  1  branch 1 beat pending
- o1_ready  in  1  branch 1 consumer ready

## Operation
State
- Data register `dat`, driven onto both o0_dat and o1_dat.
- Pending flags `pend0` and `pend1`. o0_valid = pend0 and o1_valid = pend1, both driven straight from flops.
- The flag pair encodes four states:
  - IDLE (00)
  - BOTH (11)
  - ONLY0 (10): branch 1 has already taken the beat
  - ONLY1 (01): branch 0 has already taken the beat

Handshake signals
- fireK = pendK & oK_ready.
- i_ready = (~pend0 | o0_ready) & (~pend1 | o1_ready). This is combinational from the consumer readies, so a slot freed this cycle can be refilled in the same cycle.
- acc = i_valid & i_ready.

Per-edge update
- On acc: dat ← i_dat, pend0 ← en0, pend1 ← en1.
- Otherwise: pendK ← pendK & ~oK_ready, and dat holds.

Rules and boundary cases
- en0 = en1 = 0 at acceptance: the beat is consumed and dropped. The state stays IDLE and no valid is raised.
- Stability: while pendK = 1, oK_valid stays high and oK_dat stays constant until fireK.
- Acceptance in the same cycle as a completing fire is the full-throughput case. It must not lose the fire or duplicate the beat.
- en0/en1 changes while a beat is pending have no effect on that beat.
- A branch whose en bit was 0 ignores its ready input for that beat.
- Reset asserted mid-operation:
  - Both flags clear immediately (asynchronously) and all pending beats are lost.
  - dat resets to 0.
  - The producer must treat any unaccepted beat as still owned by itself.

## Timing
- Reset values:
  - i_ready = 1 (follows from pend = 00).
  - o0_valid = o1_valid = 0.
  - o0_dat = o1_dat = 0.
- Latency: a beat accepted at edge N appears as oK_valid immediately after edge N, i.e. one cycle after i_valid & i_ready is sampled.
- Throughput:
  - 1 beat/cycle when every enabled branch is ready each cycle.
  - Otherwise the rate is limited by the slowest enabled branch.
- No combinational path from i_valid or i_dat to any output. One combinational path exists: o0_ready/o1_ready → i_ready.

## Configuration
- Macro: FORK_CTRL_STATS_EN.
- Defined: adds two output ports, each reset to 0:
  - beat_cnt (32 bits): increments on every acc, including dropped beats; wraps 0xFFFFFFFF → 0.
  - stall_cnt (32 bits): increments on every cycle with i_valid & ~i_ready; wraps the same way.
- Not defined: neither port nor any counter logic exists; all other behaviour is identical.

## Test plan
1. Reset, then check outputs. Hold RST_N low for 3 cycles → i_ready = 1, both valids 0, both data outputs 0. Release reset → same values persist while i_valid = 0.
2. Streaming. en0 = en1 = 1, both readies held 1, i_valid held 1, i_dat = 1,2,3,4 on consecutive cycles → both branches show 1,2,3,4 on consecutive cycles, one cycle delayed. i_ready stays 1 throughout.
3. Skewed consumers. o1_ready = 0 for 3 cycles after 0xA5 is accepted:
   - o0 fires once, then the state is ONLY1.
   - i_ready stays 0 and o1_dat = 0xA5 stays stable.
   - When o1_ready rises, 0xA5 fires on o1 and the next beat is accepted that same cycle.
4. Masking and drop:
   - en0 = 0, en1 = 1, accept 0x11 → only o1_valid rises; o0_ready toggling has no effect.
   - en0 = en1 = 0, accept 0x22 → no valid rises, i_ready stays 1.
5. Reset mid-beat. Assert RST_N low while in state BOTH holding 0x5A, with no clock edge → both valids drop to 0 immediately.
6. Statistics (with FORK_CTRL_STATS_EN defined). Accept 5 beats, one of them dropped, with 4 stall cycles → beat_cnt = 5, stall_cnt = 4. Preload the counters via force to 0xFFFFFFFF and accept one beat → beat_cnt = 0.
